rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares one single-port synchronous ROM/RAM image between the HPS download stream
//  (ioctl_wr/addr/dout) and the game CPU's read port. Sits between hps_io and williams2,
//  and replaces the direct dn_addr/dn_data/dn_wr hookup.
//  Download writes have absolute priority. CPU reads are serviced only outside download.
//  The block signals load completion and overflow.
// PARAMETERS
//  ADDR_W    18       byte address width of the image and of both requesters
//  DATA_W    8        data width
//  ROM_SIZE  18'h30000 bytes implemented; writes at or above this address are discarded
// PORTS
//  clk_sys      in   1       sole clock
//  reset_n      in   1       synchronous, active-low reset
//  dn_download  in   1       download in progress (level)
//  dn_wr        in   1       one-cycle write strobe
//  dn_addr      in   ADDR_W  download byte address
//  dn_data      in   DATA_W  download byte
//  dn_busy      out  1       holding register occupied
//  dn_overflow  out  1       sticky: strobe arrived while holding full and not draining
//  load_done    out  1       image complete and valid for CPU use
//  bytes_loaded out  ADDR_W  count of accepted in-range writes, saturating
//  cpu_req      in   1       read request (level, held until cpu_ack)
//  cpu_addr     in   ADDR_W  read address, stable while cpu_req=1
//  cpu_ack      out  1       one-cycle pulse; cpu_data valid in the same cycle
//  cpu_data     out  DATA_W  read data, held until the next ack
//  mem_addr     out  ADDR_W  memory address
//  mem_we       out  1       memory write enable
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, valid 1 cycle after the address is presented
// BEHAVIOUR
//  Reset, when reset_n=0 at a clk edge:
//   - all outputs return to 0: dn_busy, dn_overflow, load_done, bytes_loaded, cpu_ack,
//     cpu_data, mem_addr, mem_we, mem_wdata
//   - FSM returns to IDLE and the holding register is emptied
//   - a reset in mid-download discards the pending byte; load_done stays 0 until a
//     complete download finishes
//  Holding register (1 entry):
//   - captures dn_addr/dn_data on dn_wr when empty, or in the same cycle it drains
//     (drain and refill together is legal)
//   - a strobe while full and not draining drops the byte and sets dn_overflow
//   - dn_overflow clears only on reset or on a rising edge of dn_download
//  FSM states: IDLE, WRITE, RD_ADDR, RD_DATA
//   - IDLE -> WRITE when the holding register is full. This has priority over everything.
//   - IDLE -> RD_ADDR when cpu_req=1, dn_download=0 and load_done=1.
//   - WRITE (1 cycle):
//       - mem_we=1 and mem_addr/mem_wdata come from the holding register
//       - if addr >= ROM_SIZE, mem_we=0 and the count is not incremented
//       - otherwise bytes_loaded += 1, saturating at all-ones
//       - go to WRITE if refilled this cycle, else IDLE
//   - RD_ADDR: mem_addr=cpu_addr, mem_we=0 -> RD_DATA.
//   - RD_DATA: cpu_data<=mem_rdata and cpu_ack=1 in the following cycle -> IDLE.
//       - CPU read latency = 3 clk from IDLE with cpu_req seen to cpu_ack.
//       - A write arriving during RD_ADDR/RD_DATA waits in the holding register; the read
//         is never aborted.
//  load_done:
//   - set in the cycle after dn_download falls and the holding register is empty;
//     if a byte is still pending, set after it drains
//   - cleared, and bytes_loaded zeroed, on a dn_download rising edge
//  While dn_download=1 or load_done=0:
//   - cpu_req is not granted and cpu_ack stays 0
//   - a request pending at the download start is served after load_done
//  mem_we is never 1 outside WRITE. Exactly one memory access per cycle.
// STRUCTURE
//  Shared package rom_arb_pkg:
//   - arb_state_e enum (IDLE, WRITE, RD_ADDR, RD_DATA)
//   - ROM_SIZE_DEFAULT localparam
//  Sub-module dn_hold_reg holds the 1-entry holding register with refill-on-drain and
//  overflow detect. The FSM, counters and the edge detector on dn_download live in the top.
// TESTING
//  1. Reset, then download 4 bytes at addr 0..3 (AA,BB,CC,DD) with strobes 4 clk apart,
//     then drop dn_download
//     -> 4 mem_we pulses with matching data; bytes_loaded=4; load_done=1 one clk later.
//  2. After T1, cpu_req with addr 2 -> mem_addr=2 in RD_ADDR; cpu_ack 3 clk later
//     with cpu_data=CC.
//  3. Back-to-back dn_wr on consecutive cycles (addr 10,11,12)
//     -> all three written via drain/refill; dn_overflow=0.
//  4. Raise cpu_req during RD_DATA of a read while a dn_wr arrives
//     -> the read completes with ack, then the WRITE executes on the next IDLE.
//  5. dn_wr at addr 18'h30000
//     -> mem_we stays 0 and bytes_loaded is unchanged.
//  6. reset_n=0 mid-download with the holding register full
//     -> all outputs are 0 next clk; cpu_req is not acked until a new download completes.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the ROM image port arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        RD_ADDR,
        RD_DATA
    } arb_state_e;

    localparam int unsigned ROM_SIZE_DEFAULT = 32'h0003_0000;

endpackage

// File: rtl/rom_port_arbiter_hold.sv
// One-entry holding register for download bytes: refills in the cycle it drains,
// flags a sticky overflow when a strobe finds it full and not draining.
module dn_hold_reg #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              drain,
    input  logic              ovf_clr,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              overflow
);

    logic              full_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              overflow_reg;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            full_reg     <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr && (!full_reg || drain)) begin
                full_reg <= 1'b1;
                addr_reg <= wr_addr;
                data_reg <= wr_data;
            end else if (drain) begin
                full_reg <= 1'b0;
            end
            // A drop in the same cycle as the clear still counts as an overflow.
            if (wr && full_reg && !drain) begin
                overflow_reg <= 1'b1;
            end else if (ovf_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign full     = full_reg;
    assign addr     = addr_reg;
    assign data     = data_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates a single-port ROM image between the HPS download stream (priority)
// and CPU reads, which are only granted once a complete image has been loaded.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          ADDR_W   = 18,
    parameter int          DATA_W   = 8,
    parameter int unsigned ROM_SIZE = ROM_SIZE_DEFAULT
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              dn_download,
    input  logic              dn_wr,
    input  logic [ADDR_W-1:0] dn_addr,
    input  logic [DATA_W-1:0] dn_data,
    output logic              dn_busy,
    output logic              dn_overflow,
    output logic              load_done,
    output logic [ADDR_W-1:0] bytes_loaded,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] ROM_LIMIT = ADDR_W'(ROM_SIZE);

    arb_state_e        state_reg;
    logic              dn_download_reg;
    logic              armed_reg;
    logic              load_done_reg;
    logic [ADDR_W-1:0] bytes_loaded_reg;
    logic              cpu_ack_reg;
    logic [DATA_W-1:0] cpu_data_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_we_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              drain;
    logic              dl_rise;
    logic              read_grant;
    logic              in_range;

    assign dl_rise    = dn_download & ~dn_download_reg;
    // The holding register empties on the edge that loads the memory write registers.
    assign drain      = hold_full & ((state_reg == IDLE) | (state_reg == WRITE));
    // The ack cycle is IDLE with cpu_req still high; do not restart that same read.
    assign read_grant = cpu_req & ~dn_download & load_done_reg & ~cpu_ack_reg;
    assign in_range   = hold_addr < ROM_LIMIT;

    dn_hold_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .wr       (dn_wr),
        .wr_addr  (dn_addr),
        .wr_data  (dn_data),
        .drain    (drain),
        .ovf_clr  (dl_rise),
        .full     (hold_full),
        .addr     (hold_addr),
        .data     (hold_data),
        .overflow (dn_overflow)
    );

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            // Reset high so a download already under way at reset is never treated as complete.
            dn_download_reg  <= 1'b1;
            armed_reg        <= 1'b0;
            load_done_reg    <= 1'b0;
            bytes_loaded_reg <= '0;
            cpu_ack_reg      <= 1'b0;
            cpu_data_reg     <= '0;
            mem_addr_reg     <= '0;
            mem_we_reg       <= 1'b0;
            mem_wdata_reg    <= '0;
        end else begin
            dn_download_reg <= dn_download;
            cpu_ack_reg     <= 1'b0;
            mem_we_reg      <= 1'b0;

            unique case (state_reg)
                IDLE, WRITE: begin
                    if (hold_full) begin
                        state_reg     <= WRITE;
                        mem_addr_reg  <= hold_addr;
                        mem_wdata_reg <= hold_data;
                        if (in_range) begin
                            mem_we_reg <= 1'b1;
                            if (bytes_loaded_reg != '1) begin
                                bytes_loaded_reg <= bytes_loaded_reg + 1'b1;
                            end
                        end
                    end else if (state_reg == IDLE && read_grant) begin
                        state_reg    <= RD_ADDR;
                        mem_addr_reg <= cpu_addr;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                RD_ADDR: begin
                    state_reg <= RD_DATA;
                end
                RD_DATA: begin
                    cpu_data_reg <= mem_rdata;
                    cpu_ack_reg  <= 1'b1;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            if (dl_rise) begin
                load_done_reg    <= 1'b0;
                bytes_loaded_reg <= '0;
                armed_reg        <= 1'b1;
            end else if (armed_reg && !dn_download && !hold_full) begin
                load_done_reg <= 1'b1;
                armed_reg     <= 1'b0;
            end
        end
    end

    assign dn_busy      = hold_full;
    assign load_done    = load_done_reg;
    assign bytes_loaded = bytes_loaded_reg;
    assign cpu_ack      = cpu_ack_reg;
    assign cpu_data     = cpu_data_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_we       = mem_we_reg;
    assign mem_wdata    = mem_wdata_reg;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Scoreboard bench for rom_port_arbiter: expected writes/reads are queued when driven
// and popped when the DUT issues mem_we or cpu_ack.
module tb_rom_port_arbiter;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 8;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              dn_download;
    logic              dn_wr;
    logic [ADDR_W-1:0] dn_addr;
    logic [DATA_W-1:0] dn_data;
    logic              dn_busy;
    logic              dn_overflow;
    logic              load_done;
    logic [ADDR_W-1:0] bytes_loaded;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    logic [DATA_W-1:0] rd_q[$];
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks     = 0;
    int n_fail       = 0;
    int wr_count     = 0;
    int ack_count    = 0;
    int cyc          = 0;
    int last_ack_cyc = -1;
    int last_wr_cyc  = -1;

    always #5 clk_sys = ~clk_sys;

    rom_port_arbiter dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .dn_download  (dn_download),
        .dn_wr        (dn_wr),
        .dn_addr      (dn_addr),
        .dn_data      (dn_data),
        .dn_busy      (dn_busy),
        .dn_overflow  (dn_overflow),
        .load_done    (load_done),
        .bytes_loaded (bytes_loaded),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_ack      (cpu_ack),
        .cpu_data     (cpu_data),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Synchronous single-port memory with one-cycle read latency.
    always @(posedge clk_sys) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (reset_n === 1'b1) begin
            if (mem_we === 1'b1) begin
                wr_count++;
                last_wr_cyc = cyc;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                    $display("wr   addr=%05h data=%02h", mem_addr, mem_wdata);
                end
            end
            if (cpu_ack === 1'b1) begin
                ack_count++;
                last_ack_cyc = cyc;
                if (rd_q.size() == 0) begin
                    check("ack_unexpected", 32'(cpu_ack), 32'd0);
                end else begin
                    logic [DATA_W-1:0] d;
                    d = rd_q.pop_front();
                    check("rd_data", 32'(cpu_data), 32'(d));
                    $display("rd   ack  data=%02h", cpu_data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit expect_wr);
        dn_wr   = 1'b1;
        dn_addr = a;
        dn_data = d;
        if (expect_wr) wr_q.push_back('{addr: a, data: d});
        tick(1);
        dn_wr = 1'b0;
    endtask

    task automatic wait_ack(input string tag, input int max);
        int n;
        n = 0;
        forever begin
            @(negedge clk_sys);
            if (cpu_ack === 1'b1) break;
            n++;
            if (n > max) begin
                check({tag, "_timeout"}, 32'(cpu_ack), 32'd1);
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(dn_busy),      32'd0);
        check({tag, "_ovf"},    32'(dn_overflow),  32'd0);
        check({tag, "_done"},   32'(load_done),    32'd0);
        check({tag, "_bytes"},  32'(bytes_loaded), 32'd0);
        check({tag, "_ack"},    32'(cpu_ack),      32'd0);
        check({tag, "_cdata"},  32'(cpu_data),     32'd0);
        check({tag, "_maddr"},  32'(mem_addr),     32'd0);
        check({tag, "_we"},     32'(mem_we),       32'd0);
        check({tag, "_wdata"},  32'(mem_wdata),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [DATA_W-1:0] t1_data [4];
        int start;
        int acks_before;
        t1_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

        reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cpu_req = 1'b0; cpu_addr = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check_all_zero("reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        tick(3);

        // Test 1: four-byte download, strobes 4 clk apart
        dn_download = 1'b1;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            strobe(ADDR_W'(i), t1_data[i], 1'b1);
            tick(3);
        end
        tick(2);
        check("t1_bytes", 32'(bytes_loaded), 32'd4);
        check("t1_wr_count", 32'(wr_count), 32'd4);
        check("t1_wr_pending", 32'(wr_q.size()), 32'd0);
        dn_download = 1'b0;
        @(negedge clk_sys);
        check("t1_done_early", 32'(load_done), 32'd0);
        @(negedge clk_sys);
        check("t1_done", 32'(load_done), 32'd1);
        @(posedge clk_sys); #1;

        // Test 2: read address 2, three-cycle latency
        rd_q.push_back(8'hCC);
        cpu_addr = 18'd2;
        cpu_req  = 1'b1;
        start    = cyc;
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("t2_rd_addr", 32'(mem_addr), 32'd2);
        check("t2_rd_we", 32'(mem_we), 32'd0);
        wait_ack("t2_ack", 20);
        check("t2_latency", 32'(cyc - start), 32'd3);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        tick(2);

        // Test 3: back-to-back strobes drain and refill without overflow
        dn_download = 1'b1;
        tick(1);
        @(negedge clk_sys);
        check("t3_done_clr", 32'(load_done), 32'd0);
        check("t3_bytes_clr", 32'(bytes_loaded), 32'd0);
        @(posedge clk_sys); #1;
        dn_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dn_addr = ADDR_W'(10 + i);
            dn_data = DATA_W'(8'h10 + i);
            wr_q.push_back('{addr: dn_addr, data: dn_data});
            tick(1);
        end
        dn_wr = 1'b0;
        tick(4);
        check("t3_ovf", 32'(dn_overflow), 32'd0);
        check("t3_bytes", 32'(bytes_loaded), 32'd3);
        check("t3_wr_pending", 32'(wr_q.size()), 32'd0);
        dn_download = 1'b0;
        tick(3);
        check("t3_done", 32'(load_done), 32'd1);

        // Test 4: strobe during RD_DATA waits until after the ack
        rd_q.push_back(8'h11);
        cpu_addr = 18'd11;
        cpu_req  = 1'b1;
        tick(2);
        strobe(18'd20, 8'h5A, 1'b1);
        wait_ack("t4_ack", 20);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        tick(3);
        check("t4_wr_after_ack", 32'(last_wr_cyc - last_ack_cyc), 32'd1);
        check("t4_bytes", 32'(bytes_loaded), 32'd4);
        rd_q.push_back(8'h5A);
        cpu_addr = 18'd20;
        cpu_req  = 1'b1;
        start    = cyc;
        wait_ack("t4_rb_ack", 20);
        check("t4_rb_latency", 32'(cyc - start), 32'd3);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        tick(2);

        // Test 5: out-of-range write is discarded, last in-range address accepted
        strobe(18'h30000, 8'hEE, 1'b0);
        tick(4);
        check("t5_bytes_oor", 32'(bytes_loaded), 32'd4);
        strobe(18'h2FFFF, 8'h3C, 1'b1);
        tick(4);
        check("t5_bytes_edge", 32'(bytes_loaded), 32'd5);

        // Overflow: two strobes while a read holds the port
        rd_q.push_back(8'hAA);
        cpu_addr = 18'd0;
        cpu_req  = 1'b1;
        tick(1);
        strobe(18'd21, 8'h21, 1'b1);
        strobe(18'd22, 8'h22, 1'b0);
        wait_ack("ovf_ack", 20);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        tick(3);
        check("ovf_set", 32'(dn_overflow), 32'd1);
        check("ovf_busy", 32'(dn_busy), 32'd0);
        check("ovf_bytes", 32'(bytes_loaded), 32'd6);

        // Test 6: reset mid-download with the holding register full
        dn_download = 1'b1;
        tick(1);
        @(negedge clk_sys);
        check("t6_ovf_clr", 32'(dn_overflow), 32'd0);
        @(posedge clk_sys); #1;
        strobe(18'd30, 8'h99, 1'b0);
        check("t6_busy_pre", 32'(dn_busy), 32'd1);
        reset_n = 1'b0;
        tick(1);
        @(negedge clk_sys);
        check_all_zero("t6_reset");
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        tick(2);
        dn_download = 1'b0;
        acks_before = ack_count;
        cpu_addr = 18'd2;
        cpu_req  = 1'b1;
        tick(10);
        check("t6_no_ack", 32'(ack_count), 32'(acks_before));
        check("t6_no_done", 32'(load_done), 32'd0);
        dn_download = 1'b1;
        tick(2);
        strobe(18'd2, 8'h77, 1'b1);
        tick(3);
        rd_q.push_back(8'h77);
        dn_download = 1'b0;
        wait_ack("t6_ack", 40);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        tick(2);
        check("t6_ack_count", 32'(ack_count), 32'(acks_before + 1));
        check("t6_rd_pending", 32'(rd_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
